// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath family: default widths, divider FSM states
// and saturation helpers derived from an arbitrary data width (up to 32 bits).
package mac_pkg;

  localparam int unsigned MAC_DW = 16;
  localparam int unsigned MAC_VW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Largest positive two's-complement value of width w.
  function automatic logic [31:0] sat_max(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Most negative two's-complement value of width w.
  function automatic logic [31:0] sat_min(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/mac_div_core.sv
// Unsigned restoring division of magnitudes, MSB first, one quotient bit per step.
module mac_div_core
  import mac_pkg::*;
#(
  parameter int unsigned DW = MAC_DW,
  parameter int unsigned VW = MAC_VW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          step,
  input  logic [DW:0]   a_mag,
  input  logic [VW:0]   b_mag,
  output logic          last_c,
  output logic [DW-1:0] q_nxt_c,
  output logic [VW:0]   r_nxt_c
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  logic [DW-1:0] qsh;
  logic [VW:0]   pr;
  logic [VW:0]   b_reg;
  logic [CW-1:0] cnt;
  logic          fits;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    fits    = ({pr, qsh[DW-1]} >= {1'b0, b_reg});
    r_nxt_c = fits ? (VW+1)'({pr, qsh[DW-1]} - {1'b0, b_reg})
                   : (VW+1)'({pr, qsh[DW-1]});
    q_nxt_c = {qsh[DW-2:0], fits};
    last_c  = (cnt == '0);
  end

  // qsh starts as the dividend and fills with quotient bits as they resolve.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qsh   <= '0;
      pr    <= '0;
      b_reg <= '0;
      cnt   <= '0;
    end else if (load) begin
      qsh   <= a_mag[DW-1:0];
      pr    <= (VW+1)'(a_mag[DW]);
      b_reg <= b_mag;
      cnt   <= CW'(DW - 1);
    end else if (step) begin
      qsh <= q_nxt_c;
      pr  <= r_nxt_c;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/mac_div.sv
// Iterative signed divider with valid/ready handshakes, truncating toward zero.
// Optional MAC_DIV_FLAGS_EN adds divide-by-zero (dz) and overflow (ovf) status outputs.
module mac_div
  import mac_pkg::*;
#(
  parameter int unsigned DW = MAC_DW,
  parameter int unsigned VW = MAC_VW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
`ifdef MAC_DIV_FLAGS_EN
  ,
  output logic          dz,
  output logic          ovf
`endif
);

  localparam logic [DW-1:0] Q_MAX = DW'(sat_max(DW));
  localparam logic [DW-1:0] Q_MIN = DW'(sat_min(DW));

  div_state_e    state, state_d;
  logic          load, step, last_c;
  logic          accept_c, div_zero_c, ovf_c;
  logic          q_neg, r_neg, ovf_pend;
  logic          oval_d;
  logic [DW-1:0] quot_d, q_nxt_c;
  logic [VW-1:0] rem_d;
  logic [VW:0]   r_nxt_c;
  logic [DW:0]   a_ext, a_mag;
  logic [VW:0]   b_ext, b_mag;

  // Magnitudes carry one extra bit so the most negative operand is represented exactly.
  always_comb begin
    a_ext      = {dividend[DW-1], dividend};
    b_ext      = {divisor[VW-1], divisor};
    a_mag      = dividend[DW-1] ? -a_ext : a_ext;
    b_mag      = divisor[VW-1] ? -b_ext : b_ext;
    accept_c   = in_valid && in_ready;
    div_zero_c = (divisor == '0);
    ovf_c      = (dividend == Q_MIN) && (divisor == '1);
  end

  mac_div_core #(.DW(DW), .VW(VW)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .step    (step),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .last_c  (last_c),
    .q_nxt_c (q_nxt_c),
    .r_nxt_c (r_nxt_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next state plus next values of the registered result outputs.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    oval_d  = out_valid;
    quot_d  = quotient;
    rem_d   = remainder;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (div_zero_c) begin
            state_d = DONE;
            oval_d  = 1'b1;
            quot_d  = dividend[DW-1] ? Q_MIN : Q_MAX;
            rem_d   = '0;
          end else begin
            state_d = CALC;
            load    = 1'b1;
          end
        end
      end
      CALC: begin
        step = 1'b1;
        if (last_c) begin
          state_d = DONE;
          oval_d  = 1'b1;
          if (ovf_pend) begin
            quot_d = Q_MAX;
            rem_d  = '0;
          end else begin
            quot_d = q_neg ? -q_nxt_c : q_nxt_c;
            rem_d  = VW'(r_neg ? -r_nxt_c : r_nxt_c);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          oval_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      ovf_pend  <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= oval_d;
      quotient  <= quot_d;
      remainder <= rem_d;
      if (load) begin
        q_neg    <= dividend[DW-1] ^ divisor[VW-1];
        r_neg    <= dividend[DW-1];
        ovf_pend <= ovf_c;
      end
    end
  end

`ifdef MAC_DIV_FLAGS_EN
  // Status flags are only meaningful while out_valid is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dz  <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && accept_c) begin
      dz  <= div_zero_c;
      ovf <= 1'b0;
    end else if (state == CALC && last_c) begin
      dz  <= 1'b0;
      ovf <= ovf_pend;
    end else if (state == DONE && out_ready) begin
      dz  <= 1'b0;
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mac_div.sv
// Directed-vector bench for mac_div with hand-computed quotient/remainder/latency.
module tb_mac_div;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
`ifdef MAC_DIV_FLAGS_EN
  logic        dz;
  logic        ovf;
`endif

  int n_cmp;
  int n_bad;

  mac_div #(.DW(16), .VW(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef MAC_DIV_FLAGS_EN
    ,
    .dz        (dz),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // One complete transaction: offer operands, wait for result, handshake it.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input int elat,
                         input logic [1:0] ef);
    int lat;
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check({tag, ":in_ready_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    wait_out(lat);
    check({tag, ":latency"}, 32'(lat), 32'(elat));
    check({tag, ":quotient"}, 32'(quotient), 32'(eq));
    check({tag, ":remainder"}, 32'(remainder), 32'(er));
`ifdef MAC_DIV_FLAGS_EN
    check({tag, ":flags"}, 32'({dz, ovf}), 32'(ef));
`else
    if (ef > 2'd3) check({tag, ":flags_arg"}, 32'(ef), 32'd0);
`endif
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ":out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ":in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    clk       = 1'b0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    n_cmp     = 0;
    n_bad     = 0;

    @(negedge clk);
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:quotient", 32'(quotient), 32'd0);
    check("rst:remainder", 32'(remainder), 32'd0);
    check("rst:in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    //       tag          dividend  divisor  quotient  rem    lat  {dz,ovf}
    run_div("p1000_7",   16'd1000, 8'd7,    16'd142,  8'd6,  17, 2'b00);
    run_div("n1000_7",   16'hFC18, 8'd7,    16'hFF72, 8'hFA, 17, 2'b00);
    run_div("p100_n3",   16'd100,  8'hFD,   16'hFFDF, 8'd1,  17, 2'b00);
    run_div("n100_n3",   16'hFF9C, 8'hFD,   16'h0021, 8'hFF, 17, 2'b00);
    run_div("min_n1",    16'h8000, 8'hFF,   16'h7FFF, 8'd0,  17, 2'b01);
    run_div("p5_0",      16'd5,    8'd0,    16'h7FFF, 8'd0,  1,  2'b10);
    run_div("n5_0",      16'hFFFB, 8'd0,    16'h8000, 8'd0,  1,  2'b10);
    run_div("min_1",     16'h8000, 8'd1,    16'h8000, 8'd0,  17, 2'b00);
    run_div("max_n128",  16'h7FFF, 8'h80,   16'hFF01, 8'h7F, 17, 2'b00);
    run_div("min_n128",  16'h8000, 8'h80,   16'h0100, 8'd0,  17, 2'b00);

    // Backpressure: result held, new operands wait for the result handshake.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'd77;
    divisor  = 8'd5;
    @(posedge clk);
    @(negedge clk);
    dividend = 16'hFFB3;
    wait_out(lat);
    check("bp:latency", 32'(lat), 32'd17);
    for (int i = 0; i < 3; i++) begin
      check("bp:quotient_hold", 32'(quotient), 32'd15);
      check("bp:remainder_hold", 32'(remainder), 32'd2);
      check("bp:out_valid_hold", 32'(out_valid), 32'd1);
      check("bp:in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp:out_valid_drop", 32'(out_valid), 32'd0);
    check("bp:in_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp:in_ready_busy", 32'(in_ready), 32'd0);
    wait_out(lat);
    check("bp2:latency", 32'(lat), 32'd17);
    check("bp2:quotient", 32'(quotient), 32'hFFF1);
    check("bp2:remainder", 32'(remainder), 32'hFE);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a calculation discards it.
    in_valid = 1'b1;
    dividend = 16'd1000;
    divisor  = 8'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mrst:out_valid", 32'(out_valid), 32'd0);
    check("mrst:quotient", 32'(quotient), 32'd0);
    check("mrst:remainder", 32'(remainder), 32'd0);
    check("mrst:in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mrst:no_stale_valid", 32'(out_valid), 32'd0);
    run_div("post_rst",  16'd1000, 8'd7,    16'd142,  8'd6,  17, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
